// File: rtl/reg_access_ctrl_pkg.sv
// Shared definitions for the register access controller: FSM states,
// default widths and the hard-wired zero register address.
package reg_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 2;

    localparam int unsigned REG0_ADDR = 0;

endpackage

// File: rtl/reg_access_ctrl.sv
// Single-outstanding command controller in front of a register file:
// registered write strobe, paired reads, held responses, zero-write counter.
module reg_access_ctrl
    import reg_access_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_ra,
    input  logic [ADDR_W-1:0] cmd_rb,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_a,
    output logic [DATA_W-1:0] rsp_b,
    output logic              rsp_zero,
    output logic [ADDR_W-1:0] rf_rr1,
    output logic [ADDR_W-1:0] rf_rr2,
    output logic [ADDR_W-1:0] rf_wr,
    output logic [DATA_W-1:0] rf_wd,
    output logic              rf_regwrite,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic [7:0]        zero_wr_cnt
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG0_ADDR);

    state_t state;
    logic   out_of_reset;

    // IDLE is also the reset state; cmd_ready waits for the first edge after release.
    assign cmd_ready = out_of_reset && (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            out_of_reset <= 1'b0;
            rf_rr1       <= '0;
            rf_rr2       <= '0;
            rf_wr        <= '0;
            rf_wd        <= '0;
            rf_regwrite  <= 1'b0;
            rsp_a        <= '0;
            rsp_b        <= '0;
            rsp_zero     <= 1'b0;
            zero_wr_cnt  <= '0;
        end else begin
            out_of_reset <= 1'b1;
            rf_regwrite  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_write) begin
                            rf_wr       <= cmd_ra;
                            rf_wd       <= cmd_wdata;
                            // Strobe is set here so it is high for the whole WRITE cycle.
                            rf_regwrite <= (cmd_ra != ZERO_ADDR);
                            state       <= WRITE;
                        end else begin
                            rf_rr1 <= cmd_ra;
                            rf_rr2 <= cmd_rb;
                            state  <= READ;
                        end
                    end
                end
                WRITE: begin
                    rsp_a    <= '0;
                    rsp_b    <= '0;
                    rsp_zero <= (rf_wr == ZERO_ADDR);
                    if ((rf_wr == ZERO_ADDR) && (zero_wr_cnt != '1)) begin
                        zero_wr_cnt <= zero_wr_cnt + 8'd1;
                    end
                    state <= RESP;
                end
                READ: begin
                    rsp_a    <= rf_rd1;
                    rsp_b    <= rf_rd2;
                    rsp_zero <= 1'b0;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Self-checking bench for reg_access_ctrl: directed table, corner-case
// sequences and randomized commands against a behavioural register model.
module tb_reg_access_ctrl;

    localparam int DW = 16;
    localparam int AW = 2;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_ra = '0;
    logic [AW-1:0] cmd_rb = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_a, rsp_b;
    logic          rsp_zero;
    logic [AW-1:0] rf_rr1, rf_rr2, rf_wr;
    logic [DW-1:0] rf_wd;
    logic          rf_regwrite;
    logic [DW-1:0] rf_rd1, rf_rd2;
    logic [7:0]    zero_wr_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    reg_access_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_zero(rsp_zero),
        .rf_rr1(rf_rr1), .rf_rr2(rf_rr2), .rf_wr(rf_wr), .rf_wd(rf_wd),
        .rf_regwrite(rf_regwrite), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .zero_wr_cnt(zero_wr_cnt)
    );

    // Register file attached to the controller.
    logic [DW-1:0] rf_mem [4] = '{default: '0};
    always @(posedge clock) if (rf_regwrite) rf_mem[rf_wr] <= rf_wd;
    assign rf_rd1 = rf_mem[rf_rr1];
    assign rf_rd2 = rf_mem[rf_rr2];

    // Reference model: architectural register contents and suppressed-write count.
    logic [DW-1:0] ref_rf [4] = '{default: '0};
    int unsigned   ref_cnt = 0;

    typedef struct {
        bit        wr;
        bit [1:0]  ra;
        bit [1:0]  rb;
        bit [15:0] wd;
        bit [15:0] ea;
        bit [15:0] eb;
        bit        ez;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want event at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_step(input bit wr, input bit [1:0] ra, input bit [1:0] rb,
                              input bit [15:0] wd, output bit [15:0] ea,
                              output bit [15:0] eb, output bit ez);
        if (wr) begin
            ea = '0;
            eb = '0;
            if (ra == 0) begin
                ez = 1'b1;
                if (ref_cnt < 255) ref_cnt++;
            end else begin
                ez = 1'b0;
                ref_rf[ra] = wd;
            end
        end else begin
            ea = ref_rf[ra];
            eb = ref_rf[rb];
            ez = 1'b0;
        end
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        ok = cmd_ready;
        if (!ok) fail("cmd_ready_wait");
    endtask

    // One command with full latency/hold checks; d = cycles rsp_ready is withheld.
    task automatic run_cmd(input bit wr, input bit [1:0] ra, input bit [1:0] rb,
                           input bit [15:0] wd, input bit [15:0] ea,
                           input bit [15:0] eb, input bit ez, input int d);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_wdata = wd;
        tick();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_ra    = AW'($urandom);
        cmd_rb    = AW'($urandom);
        cmd_wdata = DW'($urandom);
        chk("n1_valid_ready", {rsp_valid, cmd_ready}, 2'b00);
        if (wr) begin
            chk("n1_rf_wr", rf_wr, ra);
            chk("n1_rf_wd", rf_wd, wd);
            chk("n1_regwrite", rf_regwrite, (ra != 0));
        end else begin
            chk("n1_rf_rr", {rf_rr1, rf_rr2}, {ra, rb});
            chk("n1_regwrite", rf_regwrite, 1'b0);
        end
        tick();
        chk("n2_valid_ready", {rsp_valid, cmd_ready}, 2'b10);
        chk("n2_regwrite", rf_regwrite, 1'b0);
        chk("n2_rsp_a", rsp_a, ea);
        chk("n2_rsp_b", rsp_b, eb);
        chk("n2_rsp_zero", rsp_zero, ez);
        for (int i = 0; i < d; i++) begin
            tick();
            chk("hold", {rsp_valid, cmd_ready, rf_regwrite, rsp_zero, rsp_a, rsp_b},
                {1'b1, 1'b0, 1'b0, ez, ea, eb});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("consumed", {rsp_valid, cmd_ready}, 2'b01);
    endtask

    task automatic model_and_run(input bit wr, input bit [1:0] ra, input bit [1:0] rb,
                                 input bit [15:0] wd, input int d);
        bit [15:0] ea, eb;
        bit        ez;
        model_step(wr, ra, rb, wd, ea, eb, ez);
        run_cmd(wr, ra, rb, wd, ea, eb, ez, d);
    endtask

    initial begin
        bit        ok;
        bit [15:0] ea, eb;
        bit        ez;

        tbl[0] = '{1'b1, 2'd1, 2'd0, 16'hA5A5, 16'h0000, 16'h0000, 1'b0};
        tbl[1] = '{1'b1, 2'd2, 2'd0, 16'h1234, 16'h0000, 16'h0000, 1'b0};
        tbl[2] = '{1'b0, 2'd1, 2'd2, 16'h0000, 16'hA5A5, 16'h1234, 1'b0};
        tbl[3] = '{1'b1, 2'd0, 2'd0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
        tbl[4] = '{1'b0, 2'd0, 2'd1, 16'h0000, 16'h0000, 16'hA5A5, 1'b0};
        tbl[5] = '{1'b1, 2'd3, 2'd0, 16'h0F0F, 16'h0000, 16'h0000, 1'b0};
        tbl[6] = '{1'b0, 2'd3, 2'd3, 16'h0000, 16'h0F0F, 16'h0F0F, 1'b0};
        tbl[7] = '{1'b1, 2'd1, 2'd0, 16'h0001, 16'h0000, 16'h0000, 1'b0};
        tbl[8] = '{1'b0, 2'd2, 2'd1, 16'h0000, 16'h1234, 16'h0001, 1'b0};

        // Reset behaviour
        #1 reset_n = 1'b0;
        #1;
        chk("rst_ctrl", {cmd_ready, rsp_valid, rf_regwrite, rsp_zero}, 4'b0000);
        chk("rst_rf", {rf_rr1, rf_rr2, rf_wr, rf_wd}, '0);
        chk("rst_rsp", {rsp_a, rsp_b, zero_wr_cnt}, '0);
        tick();
        chk("rst_ready_edge", cmd_ready, 1'b0);
        reset_n = 1'b1;
        #1;
        chk("rel_ready_pre_edge", cmd_ready, 1'b0);
        tick();
        chk("rel_ready_post_edge", {cmd_ready, rsp_valid}, 2'b10);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            model_step(tbl[i].wr, tbl[i].ra, tbl[i].rb, tbl[i].wd, ea, eb, ez);
            run_cmd(tbl[i].wr, tbl[i].ra, tbl[i].rb, tbl[i].wd,
                    tbl[i].ea, tbl[i].eb, tbl[i].ez, i % 3);
            chk("tbl_cnt", zero_wr_cnt, ref_cnt[7:0]);
        end
        model_and_run(1'b0, 2'd1, 2'd3, 16'h0, 5);

        // Back-to-back commands, cmd_valid and rsp_ready held high
        begin
            bit        cw [6];
            bit [1:0]  cra [6];
            bit [1:0]  crb [6];
            bit [15:0] cwd [6];
            bit [32:0] expq [$];
            bit [32:0] e;
            int        idx = 0, got = 0, cyc = 0, last_acc = -1;
            bit        acc, cons;
            for (int i = 0; i < 6; i++) begin
                cw[i]  = (i % 2 == 0);
                cra[i] = 2'(i % 4);
                crb[i] = 2'((i + 1) % 4);
                cwd[i] = 16'(16'h1111 * (i + 1));
            end
            wait_ready(ok);
            rsp_ready = 1'b1;
            cmd_valid = 1'b1;
            cmd_write = cw[0]; cmd_ra = cra[0]; cmd_rb = crb[0]; cmd_wdata = cwd[0];
            while (got < 6 && cyc < 60) begin
                acc  = cmd_valid && cmd_ready;
                cons = rsp_valid && rsp_ready;
                if (cons) begin
                    if (expq.size() == 0) fail("b2b_unexpected_rsp");
                    else begin
                        e = expq.pop_front();
                        chk("b2b_rsp", {rsp_a, rsp_b, rsp_zero}, e);
                    end
                    got++;
                end
                if (cons) chk("b2b_no_accept_on_consume", acc, 1'b0);
                tick();
                cyc++;
                if (acc) begin
                    if (last_acc >= 0) chk("b2b_spacing", cyc - last_acc, 3);
                    last_acc = cyc;
                    model_step(cw[idx], cra[idx], crb[idx], cwd[idx], ea, eb, ez);
                    expq.push_back({ea, eb, ez});
                    idx++;
                    if (idx < 6) begin
                        cmd_write = cw[idx]; cmd_ra = cra[idx];
                        cmd_rb = crb[idx]; cmd_wdata = cwd[idx];
                    end else begin
                        cmd_valid = 1'b0;
                    end
                end
            end
            if (got < 6) fail("b2b_timeout");
            cmd_valid = 1'b0;
            rsp_ready = 1'b0;
            chk("b2b_cnt", zero_wr_cnt, ref_cnt[7:0]);
        end

        // Reset asserted during the WRITE cycle
        wait_ready(ok);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_ra = 2'd2; cmd_wdata = 16'hBEEF;
        tick();
        cmd_valid = 1'b0;
        chk("wr_strobe_before_rst", rf_regwrite, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_write", {rf_regwrite, rsp_valid, cmd_ready}, 3'b000);
        chk("rst_mid_write_rf", {rf_wr, rf_wd, zero_wr_cnt}, '0);
        tick();
        chk("rst_rf_untouched", rf_mem[2], ref_rf[2]);
        reset_n = 1'b1;
        ref_cnt = 0;
        tick();
        chk("rst_release_idle", {cmd_ready, rsp_valid}, 2'b10);

        // Response pending at reset is discarded
        wait_ready(ok);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_ra = 2'd1; cmd_rb = 2'd2;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("pend_valid", rsp_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("pend_discard", {rsp_valid, rsp_a, rsp_b}, '0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("pend_release", {cmd_ready, rsp_valid}, 2'b10);

        // Register-0 writes and counter saturation
        for (int i = 0; i < 3; i++) model_and_run(1'b1, 2'd0, 2'd0, 16'(16'hC000 + i), i);
        chk("zero_cnt_3", zero_wr_cnt, 8'd3);
        for (int i = 0; i < 297; i++) model_and_run(1'b1, 2'd0, 2'd0, 16'($urandom), 0);
        chk("zero_cnt_sat", zero_wr_cnt, 8'd255);

        // Randomized commands against the reference model
        for (int i = 0; i < 80; i++) begin
            model_and_run(1'($urandom), 2'($urandom), 2'($urandom), 16'($urandom),
                          int'($urandom_range(0, 3)));
            chk("rand_cnt", zero_wr_cnt, ref_cnt[7:0]);
        end
        for (int r = 1; r < 4; r++) chk("final_rf", rf_mem[r], ref_rf[r]);
        chk("final_rf0", rf_mem[0], 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
